// File: rtl/rv32v_hazard_pkg.sv
// Shared types and widths for the RV32V hazard controller.
package rv32v_hazard_pkg;

  localparam int REFILL_CNT_W = 4;
  localparam int PERF_CNT_W   = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/rv32v_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high clear.
module rv32v_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rv32v_hazard_ctrl.sv
// Pipeline stall/flush controller for vector CSR updates.
// A committed vsetvl/vsetvli flushes the front of the pipe and holds
// decode for REFILL_CYCLES while the new vector config propagates.
// Optional performance counters are built when RV32V_HAZARD_PERF_EN is defined.
//
// state  | meaning
// IDLE   | no refill in progress; stalls come from busy chain only
// REFILL | decode held while the refill counter runs down to 1
module rv32v_hazard_ctrl
  import rv32v_hazard_pkg::*;
#(
  parameter int unsigned REFILL_CYCLES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic csr_update,
  input  logic busy_f1,
  input  logic busy_f2,
  input  logic busy_dec,
  input  logic busy_ex,
  input  logic busy_mem,
  output logic stall_f1,
  output logic stall_f2,
  output logic stall_dec,
  output logic stall_ex,
  output logic stall_mem,
  output logic flush_f1,
  output logic flush_f2,
  output logic flush_dec,
  output logic flush_ex,
  output logic flush_mem
`ifdef RV32V_HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_flush_count
`endif
);

  localparam logic [REFILL_CNT_W-1:0] REFILL_LOAD = REFILL_CNT_W'(REFILL_CYCLES);

  hazard_state_t           state, state_nxt;
  logic [REFILL_CNT_W-1:0] cnt, cnt_nxt;
  logic                    accept;
  logic                    refill_hold;
  logic                    chain_ex, chain_dec, chain_f2, chain_f1;

  // A CSR write that cannot leave memory this cycle is simply retried later.
  assign accept      = csr_update & ~busy_mem;
  assign refill_hold = (state == REFILL);

  // Backpressure chain, then flushed stages are released from their stall.
  always_comb begin
    chain_ex  = busy_ex  | busy_mem;
    chain_dec = busy_dec | chain_ex | refill_hold;
    chain_f2  = busy_f2  | chain_dec;
    chain_f1  = busy_f1  | chain_f2;

    stall_mem = busy_mem;
    stall_ex  = chain_ex  & ~accept;
    stall_dec = chain_dec & ~accept;
    stall_f2  = chain_f2  & ~accept;
    stall_f1  = chain_f1  & ~accept;

    flush_f1  = accept;
    flush_f2  = accept;
    flush_dec = accept;
    flush_ex  = accept;
    flush_mem = 1'b0;
  end

  // State and refill down-counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: any accepted flush (re)starts the refill window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = REFILL;
          cnt_nxt   = REFILL_LOAD;
        end
      end
      REFILL: begin
        if (accept) begin
          cnt_nxt = REFILL_LOAD;
        end else if (cnt == REFILL_CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef RV32V_HAZARD_PERF_EN
  // Decode-stall cycle counter.
  rv32v_sat_counter #(.W(PERF_CNT_W)) u_perf_stall (
    .clk   (CLK),
    .clr   (RST),
    .en    (stall_dec),
    .count (perf_stall_cycles)
  );

  // Accepted CSR-update flush counter.
  rv32v_sat_counter #(.W(PERF_CNT_W)) u_perf_flush (
    .clk   (CLK),
    .clr   (RST),
    .en    (accept),
    .count (perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_rv32v_hazard_ctrl.sv
// Directed self-checking bench for rv32v_hazard_ctrl (REFILL_CYCLES=2).
module tb_rv32v_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic csr_update;
  logic busy_f1, busy_f2, busy_dec, busy_ex, busy_mem;
  logic stall_f1, stall_f2, stall_dec, stall_ex, stall_mem;
  logic flush_f1, flush_f2, flush_dec, flush_ex, flush_mem;
`ifdef RV32V_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] stall_v, flush_v;
  assign stall_v = {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem};
  assign flush_v = {flush_f1, flush_f2, flush_dec, flush_ex, flush_mem};

  always #5 clk = ~clk;

  rv32v_hazard_ctrl #(.REFILL_CYCLES(2)) dut (
    .CLK        (clk),
    .RST        (rst),
    .csr_update (csr_update),
    .busy_f1    (busy_f1),
    .busy_f2    (busy_f2),
    .busy_dec   (busy_dec),
    .busy_ex    (busy_ex),
    .busy_mem   (busy_mem),
    .stall_f1   (stall_f1),
    .stall_f2   (stall_f2),
    .stall_dec  (stall_dec),
    .stall_ex   (stall_ex),
    .stall_mem  (stall_mem),
    .flush_f1   (flush_f1),
    .flush_f2   (flush_f2),
    .flush_dec  (flush_dec),
    .flush_ex   (flush_ex),
    .flush_mem  (flush_mem)
`ifdef RV32V_HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs {csr, f1, f2, dec, ex, mem}, settle, then check stall/flush vectors.
  task automatic drive_chk(input string tag, input logic [5:0] in, input logic [4:0] exp_stall,
                           input logic [4:0] exp_flush);
    {csr_update, busy_f1, busy_f2, busy_dec, busy_ex, busy_mem} = in;
    #1;
    chk({tag, "_stall"}, {27'd0, stall_v}, {27'd0, exp_stall});
    chk({tag, "_flush"}, {27'd0, flush_v}, {27'd0, exp_flush});
  endtask

  initial begin
    rst = 1'b1;
    {csr_update, busy_f1, busy_f2, busy_dec, busy_ex, busy_mem} = '0;
    #2;
    drive_chk("rst_idle", 6'b000000, 5'b00000, 5'b00000);
    drive_chk("rst_busy_ex", 6'b000010, 5'b11110, 5'b00000);
`ifdef RV32V_HAZARD_PERF_EN
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("rst_perf_flush", perf_flush_count, 32'd0);
`endif
    step();
    step();
    rst = 1'b0;
    drive_chk("post_rst", 6'b000000, 5'b00000, 5'b00000);

    // Quiet pipe stays quiet.
    for (int i = 0; i < 20; i++) begin
      step();
      drive_chk("quiet", 6'b000000, 5'b00000, 5'b00000);
    end

    // Busy propagation through the chain.
    step(); drive_chk("busy_ex",  6'b000010, 5'b11110, 5'b00000);
    step(); drive_chk("busy_mem", 6'b000001, 5'b11111, 5'b00000);
    step(); drive_chk("busy_f1",  6'b010000, 5'b10000, 5'b00000);
    step(); drive_chk("busy_dec", 6'b000100, 5'b11100, 5'b00000);
    step(); drive_chk("busy_f2",  6'b001000, 5'b11000, 5'b00000);
    step(); drive_chk("idle2",    6'b000000, 5'b00000, 5'b00000);

    // Accepted flush overrides busy_dec; decode held two cycles afterwards.
    step(); drive_chk("acc",      6'b100100, 5'b00000, 5'b11110);
    step(); drive_chk("refill1",  6'b000000, 5'b11100, 5'b00000);
    step(); drive_chk("refill2",  6'b000000, 5'b11100, 5'b00000);
    step(); drive_chk("refill_end", 6'b000000, 5'b00000, 5'b00000);

    // Restart during refill.
    step(); drive_chk("rs_acc1",  6'b100000, 5'b00000, 5'b11110);
    step(); drive_chk("rs_acc2",  6'b100000, 5'b00000, 5'b11110);
    step(); drive_chk("rs_hold1", 6'b000000, 5'b11100, 5'b00000);
    step(); drive_chk("rs_hold2", 6'b000000, 5'b11100, 5'b00000);
    step(); drive_chk("rs_end",   6'b000000, 5'b00000, 5'b00000);

    // Busy inside refill: hold window still ends after two cycles.
    step(); drive_chk("rb_acc",   6'b100000, 5'b00000, 5'b11110);
    step(); drive_chk("rb_hold1", 6'b000010, 5'b11110, 5'b00000);
    step(); drive_chk("rb_hold2", 6'b000000, 5'b11100, 5'b00000);
    step(); drive_chk("rb_end",   6'b000000, 5'b00000, 5'b00000);

    // Fresh reset, then blocked CSR update retried until memory frees.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    drive_chk("pf_start", 6'b000000, 5'b00000, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      step();
      drive_chk("blocked", 6'b100001, 5'b11111, 5'b00000);
    end
    step(); drive_chk("unblock",  6'b100000, 5'b00000, 5'b11110);
    step(); drive_chk("ub_hold1", 6'b000000, 5'b11100, 5'b00000);
    step(); drive_chk("ub_hold2", 6'b000000, 5'b11100, 5'b00000);
    step(); drive_chk("ub_end",   6'b000000, 5'b00000, 5'b00000);
`ifdef RV32V_HAZARD_PERF_EN
    chk("perf_flush", perf_flush_count, 32'd1);
    chk("perf_stall", perf_stall_cycles, 32'd5);
`endif

    // Reset in the middle of a refill aborts the hold.
    step(); drive_chk("ra_acc",   6'b100000, 5'b00000, 5'b11110);
    step(); drive_chk("ra_hold",  6'b000000, 5'b11100, 5'b00000);
    #1 rst = 1'b1;
    drive_chk("ra_in_rst", 6'b000000, 5'b00000, 5'b00000);
`ifdef RV32V_HAZARD_PERF_EN
    chk("ra_perf_stall", perf_stall_cycles, 32'd0);
    chk("ra_perf_flush", perf_flush_count, 32'd0);
`endif
    step(); rst = 1'b0;
    drive_chk("ra_rel",   6'b000000, 5'b00000, 5'b00000);
    step(); drive_chk("ra_after", 6'b000000, 5'b00000, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32v_hazard_ctrl.md
RV32V_HAZARD_CTRL -- requirements
Module: rv32v_hazard_ctrl

Interface
REQ-001 Parameter REFILL_CYCLES, default 2 (legal 1..15): cycles decode is held after a CSR-update flush.
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 csr_update  input  1  memory stage is committing a vector CSR write (vsetvl/vsetvli).
REQ-005 busy_f1, busy_f2, busy_dec, busy_ex, busy_mem  input  1 each  stage cannot accept or advance this cycle.
REQ-006 stall_f1, stall_f2, stall_dec, stall_ex, stall_mem  output  1 each  hold stage register.
REQ-007 flush_f1, flush_f2, flush_dec, flush_ex, flush_mem  output  1 each  invalidate stage register.
REQ-008 perf_stall_cycles  output  32  cycles with stall_dec high (only with RV32V_HAZARD_PERF_EN).
REQ-009 perf_flush_count  output  32  committed CSR-update flushes (only with RV32V_HAZARD_PERF_EN).

Function
REQ-010 Stall chain SHALL be combinational: stall_mem=busy_mem; stall_ex=busy_ex|stall_mem; stall_dec=busy_dec|stall_ex|refill_hold; stall_f2=busy_f2|stall_dec; stall_f1=busy_f1|stall_f2.
REQ-011 A flush SHALL be accepted when csr_update=1 and busy_mem=0; csr_update with busy_mem=1 SHALL be ignored that cycle (no flush, no state change).
REQ-012 In an accepting cycle flush_f1, flush_f2, flush_dec, flush_ex SHALL be 1 combinationally; flush_mem SHALL be 0 at all times.
REQ-013 A flushed stage SHALL have its stall output forced to 0 in that cycle (flush overrides busy).
REQ-014 FSM states: IDLE, REFILL.
REQ-015 IDLE -> REFILL on accepted flush; counter loaded with REFILL_CYCLES on that edge.
REQ-016 In REFILL refill_hold=1; counter decrements each cycle; REFILL -> IDLE on the edge where counter equals 1.
REQ-017 Accepted flush while in REFILL SHALL reassert flushes and reload the counter (restart), remaining in REFILL.
REQ-018 refill_hold SHALL be 0 in IDLE; fetch stages stall via chain only.
REQ-019 Net latency: csr_update accepted at cycle N -> stall_dec high cycles N+1..N+REFILL_CYCLES, low at N+REFILL_CYCLES+1 if no busy.

Reset
REQ-020 RST=1 SHALL asynchronously force state IDLE, counter 0, perf counters 0.
REQ-021 During and immediately after reset all stall_*/flush_* outputs SHALL follow only busy_* (no refill_hold, no flush unless csr_update accepted).
REQ-022 RST asserted mid-REFILL SHALL abort the refill; no residual hold after release.

Configuration
REQ-023 Macro RV32V_HAZARD_PERF_EN defined: perf_stall_cycles and perf_flush_count ports exist, increment on their events, saturate at 32'hFFFF_FFFF.
REQ-024 Macro undefined: both ports and all counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-025 Package rv32v_hazard_pkg SHALL hold hazard_state_t (IDLE, REFILL), REFILL_CNT_W=4, and PERF_CNT_W=32.
REQ-026 One sub-module, rv32v_sat_counter (PERF_CNT_W wide, enable, async active-high clear), instantiated twice under the macro.

Verification
REQ-027 All busy=0, csr_update=0 -> all stall/flush 0 for 20 cycles; state IDLE.
REQ-028 busy_ex=1 one cycle -> stall_ex, stall_dec, stall_f2, stall_f1 =1, stall_mem=0, same cycle.
REQ-029 csr_update=1, busy_mem=0 at cycle 10, REFILL_CYCLES=2 -> flush_f1/f2/dec/ex=1 at 10; stall_dec=1 at 11,12; 0 at 13.
REQ-030 csr_update=1 with busy_mem=1 cycles 5-7, busy_mem=0 at 8 -> first flush at cycle 8 only; perf_flush_count=1.
REQ-031 Second csr_update at cycle 11 during REFILL from cycle 10 -> flush at 11, stall_dec held through cycle 13.
REQ-032 RST pulse at cycle 11 during REFILL -> stall_dec=0 at 12 with busy=0; perf counters read 0 (macro on).
